// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared definitions for the multicycle RV32I-subset control path:
// FSM state encoding, opcode values, ALUControl encodings and ALUOp codes.
package riscv_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECR    = 4'd6,
        ST_EXECI    = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BEQ      = 4'd9,
        ST_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode
// Combinational ALU operation decode.
// Ports:
//   i_alu_op    : 2-bit ALUOp from the controller FSM
//   i_funct3    : instruction[14:12]
//   i_op_b5     : instruction[5] (distinguishes R-type from I-type)
//   i_funct7b5  : instruction[30]
//   o_alu_ctrl  : 3-bit ALUControl
module alu_ctrl_decode
    import riscv_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_op_b5,
    input  logic       i_funct7b5,
    output logic [2:0] o_alu_ctrl
);

    always_comb begin
        o_alu_ctrl = ALU_ADD;
        case (i_alu_op)
            ALUOP_ADD: o_alu_ctrl = ALU_ADD;
            ALUOP_SUB: o_alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // funct7b5 only means subtract for R-type; an I-type
                    // addi with a large immediate can have bit 30 set.
                    3'b000:  o_alu_ctrl = (i_op_b5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alu_ctrl = ALU_SLT;
                    3'b110:  o_alu_ctrl = ALU_OR;
                    3'b111:  o_alu_ctrl = ALU_AND;
                    default: o_alu_ctrl = ALU_ADD;
                endcase
            end
            default: o_alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Moore control FSM for the multicycle RV32I-subset datapath. Sequences one
// instruction over 3-5 cycles, stalls on MemReady and drives all datapath
// selects and write strobes.
// Ports:
//   clk, rst            : clock (rising edge), async active-high reset
//   op, funct3, funct7b5: instruction fields from the instruction register
//   Zero                : ALU zero flag (branch decision)
//   MemReady            : memory completes the current access this cycle
//   PCWrite, IRWrite, MemWrite, RegWrite : write strobes (forced 0 in reset)
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl : datapath selects
//   IllegalOp           : one-cycle pulse in DECODE on an unsupported opcode
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4, wait for MemReady
// DECODE   | read registers, compute branch target OldPC+imm
// MEMADR   | compute rs1+imm for lw/sw
// MEMREAD  | read data memory, wait for MemReady
// MEMWB    | write loaded data to rd
// MEMWRITE | write data memory, wait for MemReady
// EXECR    | R-type ALU operation
// EXECI    | I-type ALU operation
// ALUWB    | write ALUOut to rd
// BEQ      | compare rs1/rs2, redirect PC if equal
// JAL      | redirect PC to target, compute OldPC+4 for rd
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       IllegalOp
);

    state_t     r_state;
    state_t     w_next;
    logic       w_mem_ready;
    logic       w_pc_write;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic [1:0] w_alu_op;
    logic [1:0] w_imm_src;

    assign w_mem_ready = USE_MEM_READY ? MemReady : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_pc_write  = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_alu_op    = ALUOP_ADD;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        IllegalOp   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                w_ir_write = w_mem_ready;
                w_pc_write = w_mem_ready;
                if (w_mem_ready) w_next = ST_DECODE;
            end
            ST_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: w_next = ST_MEMADR;
                    OP_R:         w_next = ST_EXECR;
                    OP_I:         w_next = ST_EXECI;
                    OP_BEQ:       w_next = ST_BEQ;
                    OP_JAL:       w_next = ST_JAL;
                    default: begin
                        w_next    = ST_FETCH;
                        IllegalOp = 1'b1;
                    end
                endcase
            end
            ST_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = op[5] ? ST_MEMWRITE : ST_MEMREAD;
            end
            ST_MEMREAD: begin
                AdrSrc = 1'b1;
                if (w_mem_ready) w_next = ST_MEMWB;
            end
            ST_MEMWB: begin
                ResultSrc   = 2'b01;
                w_reg_write = 1'b1;
                w_next      = ST_FETCH;
            end
            ST_MEMWRITE: begin
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
                if (w_mem_ready) w_next = ST_FETCH;
            end
            ST_EXECR: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b00;
                w_alu_op = ALUOP_FUNCT;
                w_next   = ST_ALUWB;
            end
            ST_EXECI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                w_alu_op = ALUOP_FUNCT;
                w_next   = ST_ALUWB;
            end
            ST_ALUWB: begin
                w_reg_write = 1'b1;
                w_next      = ST_FETCH;
            end
            ST_BEQ: begin
                ALUSrcA    = 2'b10;
                w_alu_op   = ALUOP_SUB;
                w_pc_write = Zero;
                w_next     = ST_FETCH;
            end
            ST_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                w_pc_write = 1'b1;
                w_next     = ST_ALUWB;
            end
            default: w_next = ST_FETCH;
        endcase
    end

    always_comb begin
        w_imm_src = 2'b00;
        case (op)
            OP_SW:   w_imm_src = 2'b01;
            OP_BEQ:  w_imm_src = 2'b10;
            OP_JAL:  w_imm_src = 2'b11;
            default: w_imm_src = 2'b00;
        endcase
    end

    alu_ctrl_decode u_alu_ctrl_decode (
        .i_alu_op   (w_alu_op),
        .i_funct3   (funct3),
        .i_op_b5    (op[5]),
        .i_funct7b5 (funct7b5),
        .o_alu_ctrl (ALUControl)
    );

    // State is already FETCH during reset; gating with rst kills the
    // MemReady-driven FETCH strobes and any strobe of an interrupted state
    // in the same cycle reset rises.
    assign PCWrite  = w_pc_write  & ~rst;
    assign IRWrite  = w_ir_write  & ~rst;
    assign MemWrite = w_mem_write & ~rst;
    assign RegWrite = w_reg_write & ~rst;
    assign ImmSrc   = rst ? 2'b00 : w_imm_src;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalOp;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    int n_vec = 0;
    int n_err = 0;

    multicycle_controller #(.USE_MEM_READY(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .IllegalOp  (IllegalOp)
    );

    always #5 clk = ~clk;

    // Output bundle: pc adr mw ir rw rs[1:0] sa[1:0] sb[1:0] imm[1:0] ac[2:0] ill
    logic [16:0] outs;
    assign outs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                   ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalOp};

    function automatic logic [16:0] ov(input logic pc, input logic adr, input logic mw,
                                       input logic ir, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] imm, input logic [2:0] ac,
                                       input logic ill);
        return {pc, adr, mw, ir, rw, rs, sa, sb, imm, ac, ill};
    endfunction

    task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Check outputs mid-cycle, then advance to just after the next rising edge.
    task automatic cyc(input string tag, input logic [16:0] exp);
        @(negedge clk);
        chk_vec(tag, {15'd0, outs}, {15'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7b5 = f7;
    endtask

    // FETCH/DECODE/EXEC/ALUWB sequence for an ALU instruction, MemReady held high.
    task automatic run_alu(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic [2:0] ac);
        set_instr(o, f3, f7);
        cyc({tag, "_fetch"},  ov(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        cyc({tag, "_decode"}, ov(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
        cyc({tag, "_exec"},   ov(0,0,0,0,0,2'b00,2'b10, o[5] ? 2'b00 : 2'b01, 2'b00, ac, 0));
        cyc({tag, "_aluwb"},  ov(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; MemReady = 1'b1; Zero = 1'b0;
        set_instr(7'b0100011, 3'b010, 1'b0);
        @(negedge clk);
        chk_vec("reset_outs", {15'd0, outs}, {15'd0, ov(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0)});
        @(posedge clk); #1;
        rst = 1'b0;

        // sw, stalled in MEMWRITE, then reset asserted mid-cycle
        cyc("sw_fetch",   ov(1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000,0));
        cyc("sw_decode",  ov(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0));
        cyc("sw_memadr",  ov(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0));
        MemReady = 1'b0;
        cyc("sw_memwrite",       ov(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0));
        cyc("sw_memwrite_stall", ov(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0));
        #2 rst = 1'b1;
        #1;
        chk_vec("rst_memwrite_drop", {31'd0, MemWrite}, 32'd0);
        chk_vec("rst_mid_outs", {15'd0, outs}, {15'd0, ov(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0)});
        @(posedge clk); #1;
        rst = 1'b0; MemReady = 1'b1;

        // add / sub
        run_alu("add", 7'b0110011, 3'b000, 1'b0, 3'b000);
        run_alu("sub", 7'b0110011, 3'b000, 1'b1, 3'b001);
        run_alu("slt", 7'b0110011, 3'b010, 1'b0, 3'b101);
        run_alu("addi_b30", 7'b0010011, 3'b000, 1'b1, 3'b000);
        run_alu("andi", 7'b0010011, 3'b111, 1'b0, 3'b010);
        run_alu("ori",  7'b0010011, 3'b110, 1'b0, 3'b011);
        run_alu("xori_other", 7'b0010011, 3'b100, 1'b0, 3'b000);

        // lw with two MemReady=0 cycles in MEMREAD
        set_instr(7'b0000011, 3'b010, 1'b0);
        cyc("lw_fetch",   ov(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        cyc("lw_decode",  ov(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
        cyc("lw_memadr",  ov(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0));
        MemReady = 1'b0;
        cyc("lw_memread_s1", ov(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));
        cyc("lw_memread_s2", ov(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));
        MemReady = 1'b1;
        cyc("lw_memread",  ov(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));
        cyc("lw_memwb",    ov(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,0));

        // beq taken, with one FETCH stall first
        set_instr(7'b1100011, 3'b000, 1'b0);
        Zero = 1'b1; MemReady = 1'b0;
        cyc("beq_fetch_stall", ov(0,0,0,0,0,2'b10,2'b00,2'b10,2'b10,3'b000,0));
        MemReady = 1'b1;
        cyc("beq_fetch",  ov(1,0,0,1,0,2'b10,2'b00,2'b10,2'b10,3'b000,0));
        cyc("beq_decode", ov(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0));
        cyc("beq_taken",  ov(1,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0));
        // beq not taken
        Zero = 1'b0;
        cyc("beqn_fetch",  ov(1,0,0,1,0,2'b10,2'b00,2'b10,2'b10,3'b000,0));
        cyc("beqn_decode", ov(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0));
        cyc("beqn_beq",    ov(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0));

        // jal
        set_instr(7'b1101111, 3'b000, 1'b0);
        cyc("jal_fetch",  ov(1,0,0,1,0,2'b10,2'b00,2'b10,2'b11,3'b000,0));
        cyc("jal_decode", ov(0,0,0,0,0,2'b00,2'b01,2'b01,2'b11,3'b000,0));
        cyc("jal_jal",    ov(1,0,0,0,0,2'b00,2'b01,2'b10,2'b11,3'b000,0));
        cyc("jal_aluwb",  ov(0,0,0,0,1,2'b00,2'b00,2'b00,2'b11,3'b000,0));

        // illegal opcode
        set_instr(7'b0000000, 3'b000, 1'b0);
        cyc("ill_fetch",  ov(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        cyc("ill_decode", ov(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,1));
        cyc("ill_refetch", ov(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style control FSM for the multicycle RISC-V RV32I-subset datapath (lw, sw, R-type, I-type ALU, beq, jal). It sequences one instruction over 3–5 cycles on a shared ALU and unified memory port. It stalls on a memory-ready handshake and drives every datapath select and write strobe. ALU control uses the team's existing 3-bit encoding: 000 add, 001 sub, 010 and, 011 or, 101 slt.

## Interface
- USE_MEM_READY, default 1: when 0, MemReady is ignored and treated as 1.
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- op  in  7  instruction[6:0] from the instruction register
- funct3  in  3  instruction[14:12]
- funct7b5  in  1  instruction[30]
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction and OldPC register enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = Imm, 10 = constant 4
- ImmSrc  out  2  immediate type: 00 = I, 01 = S, 10 = B, 11 = J
- ALUControl  out  3  ALU operation, using the encoding above
- IllegalOp  out  1  one-cycle pulse when DECODE sees an unsupported opcode

## Operation
- States are FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
- Any output not listed for a state is 0.
- FETCH
  - Outputs: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite and PCWrite are both equal to MemReady.
  - Moves to DECODE when MemReady=1; otherwise holds.
- DECODE
  - Outputs: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target is computed here).
  - Next state by op: 0000011 or 0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BEQ; 1101111 → JAL.
  - Any other op → FETCH, with IllegalOp=1.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next is MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Holds until MemReady, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next is FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. MemWrite stays high until MemReady, then FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next is ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next is ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next is FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero. Next is FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Next is ALUWB, which writes PC+4 to rd.
- ImmSrc is combinational from op: 0100011 → 01, 1100011 → 10, 1101111 → 11, all others → 00.
- ALUControl is combinational from ALUOp (internal, 2 bits):
  - ALUOp 00 → 000; ALUOp 01 → 001.
  - ALUOp 10, funct3 000 → 001 if (op[5] & funct7b5), else 000.
  - ALUOp 10, funct3 010 → 101; funct3 110 → 011; funct3 111 → 010.
  - Any other funct3 → 000, with no IllegalOp.

## Timing
- rst asserted: state goes to FETCH immediately (asynchronous).
- While rst is high, all write strobes are forced to 0: PCWrite, IRWrite, MemWrite, RegWrite.
- While rst is high, the other outputs are 0, except ALUSrcB=10 and ResultSrc=10, which take their FETCH values.
- First FETCH is the first clock edge after rst deasserts.
- Cycles per instruction with MemReady held high: beq 3; R-type, I-type, sw and jal 4; lw 5.
- Each MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle. All outputs are held stable while stalled.
- Only FETCH, MEMREAD and MEMWRITE sample MemReady.
- Illegal opcode: IllegalOp is high only in the DECODE cycle. The instruction costs 2 cycles and no strobe fires.
- rst asserted mid-instruction (for example in MEMWRITE): strobes drop in the same cycle and there is no partial write.

## Structure
- Shared package riscv_pkg holds:
  - the state enum;
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL);
  - ALUControl encodings (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT);
  - ALUOp constants.
- One sub-module, alu_ctrl_decode: combinational ALUOp/funct3/op/funct7b5 → ALUControl.
- State register, next-state logic and output decode live in the top module.

## Test plan
- Reset mid-MEMWRITE: MemWrite drops the same cycle. After release, the first cycle is FETCH with IRWrite=1.
- add then sub (0x00208033, 0x40208033), MemReady=1: 4 cycles each. In EXECR, ALUControl=000 for add and 001 for sub. RegWrite=1 only in ALUWB.
- lw with MemReady low for 2 cycles in MEMREAD: 7 cycles total. AdrSrc=1 throughout MEMREAD. ResultSrc=01 and RegWrite=1 in MEMWB.
- beq: with Zero=1, PCWrite=1 in the BEQ cycle and 3 cycles total. With Zero=0, PCWrite=0 and the FSM returns to FETCH.
- jal (op 1101111): ImmSrc=11. PCWrite=1 in JAL, then ALUWB with RegWrite=1. 4 cycles total.
- Illegal op 0000000: IllegalOp pulses 1 cycle in DECODE, no strobe fires, and the FSM returns to FETCH.
